// File: rtl/alarm_sequencer.sv
// -----------------------------------------------------------------------------
// alarm_sequencer
//
// Sequences the two alarm channels of the alarm clock and shares one ringer
// between them. Each alarm runs its own IDLE / RINGING / SNOOZED machine. A
// registered arbiter hands the ringer to the lowest-index RINGING alarm
// whenever no alarm currently owns it. Ownership is never preempted.
//
// Parameters:
//   SNOOZE_SEC        snooze interval in seconds (1..1023)
//   RING_TIMEOUT_SEC  owned ring length before an automatic snooze (1..1023)
//   MAX_SNOOZE        snoozes allowed per trigger (0..3)
//
// Ports:
//   clk_pi           system clock
//   rst_n_pi         asynchronous active-low reset
//   sec_tick_pi      one-cycle pulse once per second
//   alarm_en_pi      per-alarm enable level (bit i = alarm i)
//   alarm_match_pi   per-alarm time-match level
//   snooze_pi        one-cycle debounced snooze pulse
//   dismiss_pi       one-cycle debounced dismiss pulse
//   ring_po          ringer drive, high while an owner exists
//   active_alarm_po  one-hot ringer owner, 00 when none
//   snoozed_po       bit i high while alarm i is SNOOZED
//   pending_po       bit i high while alarm i is RINGING but not owner
// -----------------------------------------------------------------------------
module alarm_sequencer #(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic       clk_pi,
  input  logic       rst_n_pi,
  input  logic       sec_tick_pi,
  input  logic [1:0] alarm_en_pi,
  input  logic [1:0] alarm_match_pi,
  input  logic       snooze_pi,
  input  logic       dismiss_pi,
  output logic       ring_po,
  output logic [1:0] active_alarm_po,
  output logic [1:0] snoozed_po,
  output logic [1:0] pending_po
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } alarm_state_e;

  localparam logic [9:0] SNOOZE_C  = SNOOZE_SEC[9:0];
  localparam logic [9:0] TIMEOUT_C = RING_TIMEOUT_SEC[9:0];
  localparam logic [1:0] MAX_C     = MAX_SNOOZE[1:0];

  logic [1:0] prev_q, prev_d;
  logic [1:0] trigger;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ringing;
  logic [1:0] snoozed;

  // A trigger fires once on the rising edge of (enable & match), so holding
  // the match for a whole minute only rings once, while enabling inside a
  // match minute triggers straight away.
  assign prev_d  = alarm_en_pi & alarm_match_pi;
  assign trigger = prev_d & ~prev_q;

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      prev_q  <= 2'b00;
      owner_q <= 2'b00;
    end else begin
      prev_q  <= prev_d;
      owner_q <= owner_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_alarm
    alarm_state_e state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    // Shared counter: elapsed ring seconds while RINGING, remaining snooze
    // seconds while SNOOZED.
    logic [9:0]   ctr_q, ctr_d;
    logic         take_snooze;

    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ctr_d       = ctr_q;
      take_snooze = 1'b0;

      if (!alarm_en_pi[gi]) begin
        // Disable overrides every other event.
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
        ctr_d   = 10'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (trigger[gi]) begin
              state_d = ST_RINGING;
              cnt_d   = 2'd0;
              ctr_d   = 10'd0;
            end
          end
          ST_RINGING: begin
            // A queued (non-owner) alarm ignores pulses and freezes its timer.
            if (owner_q[gi]) begin
              if (dismiss_pi) begin
                state_d = ST_IDLE;
                ctr_d   = 10'd0;
              end else if (snooze_pi) begin
                take_snooze = 1'b1;
              end else if (sec_tick_pi) begin
                if (ctr_q + 10'd1 == TIMEOUT_C) begin
                  take_snooze = 1'b1;
                end else begin
                  ctr_d = ctr_q + 10'd1;
                end
              end
            end
          end
          ST_SNOOZED: begin
            if (sec_tick_pi && (ctr_q != 10'd0)) begin
              if (ctr_q == 10'd1) begin
                state_d = ST_RINGING;
                ctr_d   = 10'd0;
              end else begin
                ctr_d = ctr_q - 10'd1;
              end
            end
          end
          default: state_d = ST_IDLE;
        endcase

        // Manual and automatic snooze share one rule: once the allowance is
        // used up, snoozing ends the alarm instead.
        if (take_snooze) begin
          if (cnt_q < MAX_C) begin
            state_d = ST_SNOOZED;
            ctr_d   = SNOOZE_C;
            cnt_d   = cnt_q + 2'd1;
          end else begin
            state_d = ST_IDLE;
            ctr_d   = 10'd0;
          end
        end
      end
    end

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) begin
        state_q <= ST_IDLE;
        cnt_q   <= 2'd0;
        ctr_q   <= 10'd0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ctr_q   <= ctr_d;
      end
    end

    assign ringing[gi] = (state_q == ST_RINGING);
    assign snoozed[gi] = (state_q == ST_SNOOZED);
  end

  // An owner that left RINGING is first released (ringer silent for one
  // cycle), and only the following edge grants the next RINGING alarm.
  always_comb begin
    owner_d = 2'b00;
    if (owner_q != 2'b00) begin
      if ((owner_q & ringing) != 2'b00) begin
        owner_d = owner_q;
      end
    end else if (ringing[0]) begin
      owner_d = 2'b01;
    end else if (ringing[1]) begin
      owner_d = 2'b10;
    end
  end

  assign ring_po         = |owner_q;
  assign active_alarm_po = owner_q;
  assign snoozed_po      = snoozed;
  assign pending_po      = ringing & ~owner_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alarm_sequencer
//
// Drives directed scenarios followed by random traffic into alarm_sequencer.
// Every cycle the driver steps a behavioural model of the alarm rules and
// queues the outputs expected after the next clock edge; an independent
// monitor pops one entry per edge and compares it with the DUT outputs.
// Output vector layout: {ring, active[1:0], snoozed[1:0], pending[1:0]}.
// -----------------------------------------------------------------------------
module tb_alarm_sequencer;

  localparam int SNOOZE_SEC       = 300;
  localparam int RING_TIMEOUT_SEC = 60;
  localparam int MAX_SNOOZE       = 3;

  localparam int S_IDLE = 0;
  localparam int S_RING = 1;
  localparam int S_SNZ  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [1:0] en;
  logic [1:0] match;
  logic       snz;
  logic       dis;
  logic       ring;
  logic [1:0] active;
  logic [1:0] snoozed;
  logic [1:0] pending;
  logic [6:0] dut_vec;

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] exp_q[$];

  // Reference model state
  int m_st[2];
  int m_cnt[2];
  int m_elapsed[2];
  int m_remaining[2];
  bit m_prev[2];
  int m_owner;

  always #5 clk = ~clk;

  alarm_sequencer #(
    .SNOOZE_SEC       (SNOOZE_SEC),
    .RING_TIMEOUT_SEC (RING_TIMEOUT_SEC),
    .MAX_SNOOZE       (MAX_SNOOZE)
  ) dut (
    .clk_pi          (clk),
    .rst_n_pi        (rst_n),
    .sec_tick_pi     (tick),
    .alarm_en_pi     (en),
    .alarm_match_pi  (match),
    .snooze_pi       (snz),
    .dismiss_pi      (dis),
    .ring_po         (ring),
    .active_alarm_po (active),
    .snoozed_po      (snoozed),
    .pending_po      (pending)
  );

  assign dut_vec = {ring, active, snoozed, pending};

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i]        = S_IDLE;
      m_cnt[i]       = 0;
      m_elapsed[i]   = 0;
      m_remaining[i] = 0;
      m_prev[i]      = 1'b0;
    end
    m_owner = -1;
  endfunction

  function automatic void model_snooze(input int i);
    if (m_cnt[i] < MAX_SNOOZE) begin
      m_st[i]        = S_SNZ;
      m_remaining[i] = SNOOZE_SEC;
      m_cnt[i]       = m_cnt[i] + 1;
    end else begin
      m_st[i] = S_IDLE;
    end
  endfunction

  function automatic void model_step(input logic [1:0] e, input logic [1:0] m,
                                     input logic t, input logic s, input logic d);
    int next_owner;
    bit trig;
    // Arbitration looks at the alarm states as they were before this edge.
    if (m_owner >= 0) begin
      next_owner = (m_st[m_owner] == S_RING) ? m_owner : -1;
    end else begin
      next_owner = -1;
      for (int i = 1; i >= 0; i--) begin
        if (m_st[i] == S_RING) next_owner = i;
      end
    end
    for (int i = 0; i < 2; i++) begin
      trig      = e[i] && m[i] && !m_prev[i];
      m_prev[i] = e[i] && m[i];
      if (!e[i]) begin
        m_st[i]  = S_IDLE;
        m_cnt[i] = 0;
      end else if (m_st[i] == S_IDLE) begin
        if (trig) begin
          m_st[i]      = S_RING;
          m_cnt[i]     = 0;
          m_elapsed[i] = 0;
        end
      end else if (m_st[i] == S_RING) begin
        if (m_owner == i) begin
          if (d) begin
            m_st[i] = S_IDLE;
          end else if (s) begin
            model_snooze(i);
          end else if (t) begin
            m_elapsed[i] = m_elapsed[i] + 1;
            if (m_elapsed[i] == RING_TIMEOUT_SEC) model_snooze(i);
          end
        end
      end else begin
        if (t) begin
          m_remaining[i] = m_remaining[i] - 1;
          if (m_remaining[i] == 0) begin
            m_st[i]      = S_RING;
            m_elapsed[i] = 0;
          end
        end
      end
    end
    m_owner = next_owner;
  endfunction

  function automatic logic [6:0] model_outputs();
    logic [1:0] a;
    logic [1:0] sn;
    logic [1:0] pd;
    a  = 2'b00;
    sn = 2'b00;
    pd = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (m_owner == i) a[i] = 1'b1;
      if (m_st[i] == S_SNZ) sn[i] = 1'b1;
      if (m_st[i] == S_RING && m_owner != i) pd[i] = 1'b1;
    end
    return {(m_owner >= 0), a, sn, pd};
  endfunction

  // Apply inputs for the coming edge and queue the outputs expected after it.
  task automatic drive(input logic [1:0] e, input logic [1:0] m,
                       input logic t, input logic s, input logic d);
    en    = e;
    match = m;
    tick  = t;
    snz   = s;
    dis   = d;
    model_step(e, m, t, s, d);
    exp_q.push_back(model_outputs());
  endtask

  task automatic cyc(input logic [1:0] e, input logic [1:0] m,
                     input logic t, input logic s, input logic d);
    @(negedge clk);
    drive(e, m, t, s, d);
  endtask

  // Check right after the edge that consumed the most recent cyc() inputs.
  task automatic check_after_edge(input string name, input logic [6:0] exp);
    @(posedge clk);
    #2;
    check(name, dut_vec, exp);
  endtask

  // Monitor: one queued expectation per clock edge.
  initial begin
    logic [6:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        check("outputs", dut_vec, exp_v);
      end
    end
  end

  initial begin
    #3000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached (t=%0t)", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] re;
    logic [1:0] rm;
    int guard;

    rst_n = 1'b0;
    en    = 2'b00;
    match = 2'b00;
    tick  = 1'b0;
    snz   = 1'b0;
    dis   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", dut_vec, 7'b0_00_00_00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);

    // Single alarm: latency and automatic snooze on timeout.
    cyc(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    check_after_edge("rise_plus1", 7'b0_00_00_01);
    cyc(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    check_after_edge("rise_plus2", 7'b1_01_00_00);
    repeat (70) cyc(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    check_after_edge("auto_snooze", 7'b0_00_01_00);

    // Snooze cycles until the allowance is used up; the last snooze ends it.
    for (int k = 0; k < 3; k++) begin
      guard = 0;
      while (!(m_owner == 0 && m_st[0] == S_RING) && guard < 700) begin
        cyc(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        guard++;
      end
      if (guard >= 700) begin
        n_checks++;
        n_fail++;
        $display("FAIL snooze_wait: re-ring not reached, got %0d cycles expected fewer than 700", guard);
      end
      cyc(2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
    end
    cyc(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    check_after_edge("max_snooze_idle", 7'b0_00_00_00);

    // Simultaneous triggers and handover after dismiss.
    cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    check_after_edge("both_owner0", 7'b1_01_00_10);
    cyc(2'b11, 2'b11, 1'b0, 1'b0, 1'b1);
    check_after_edge("dismiss_edge1", 7'b1_01_00_10);
    cyc(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    check_after_edge("handover_gap", 7'b0_00_00_10);
    cyc(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    check_after_edge("handover_owner1", 7'b1_10_00_00);
    cyc(2'b11, 2'b11, 1'b0, 1'b0, 1'b1);
    cyc(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);

    // Alarm 1 owns, alarm 0 queues without preemption.
    cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 2'b10, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 2'b10, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 2'b10, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    check_after_edge("no_preempt", 7'b1_10_00_01);
    cyc(2'b11, 2'b11, 1'b0, 1'b1, 1'b0);
    cyc(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    check_after_edge("snooze_handover", 7'b1_01_10_00);
    cyc(2'b11, 2'b11, 1'b0, 1'b0, 1'b1);
    cyc(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);

    // Snooze and dismiss together: dismiss wins.
    cyc(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 2'b01, 1'b0, 1'b1, 1'b1);
    cyc(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    check_after_edge("dismiss_wins", 7'b0_00_00_00);

    // Disable during snooze, then re-enable with match low.
    cyc(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 2'b01, 1'b0, 1'b1, 1'b0);
    repeat (150) cyc(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
    check_after_edge("snoozed_mid", 7'b0_00_01_00);
    cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    check_after_edge("disable_clears", 7'b0_00_00_00);
    repeat (5) cyc(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
    check_after_edge("reenable_quiet", 7'b0_00_00_00);

    // Asynchronous reset while ringing, then re-trigger on held match.
    repeat (4) cyc(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    check_after_edge("ring_before_reset", 7'b1_01_00_00);
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_vec, 7'b0_00_00_00);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    check_after_edge("retrigger_after_reset", 7'b1_01_00_00);
    cyc(2'b01, 2'b00, 1'b0, 1'b0, 1'b1);
    cyc(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);

    // Random traffic against the model.
    re = 2'b11;
    rm = 2'b00;
    for (int n = 0; n < 8000; n++) begin
      if ($urandom_range(0, 299) == 0) re[$urandom_range(0, 1)] ^= 1'b1;
      if ($urandom_range(0, 39) == 0) rm[0] = ~rm[0];
      if ($urandom_range(0, 39) == 0) rm[1] = ~rm[1];
      cyc(re, rm, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 2));
    end
    cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
